// File: rtl/pll_lock_sequencer.sv
`timescale 1ns/1ps
// pll_lock_sequencer
//   Brings up the sample-clock PLL from the reference clock domain: holds the
//   PLL in reset, waits for lock with a timeout and bounded retries, then
//   qualifies lock over a programmable window before raising ready.
//
// Optional build macro: LOCK_LOSS_COUNT_EN adds lock_loss_cnt, a saturating
//   16-bit count of READY->RESET transitions (cleared only by rst_n).
//
// Ports:
//   refclk        in   sequencer clock (PLL reference clock)
//   rst_n         in   asynchronous active-low reset
//   enable        in   1 = bring up PLL, 0 = force IDLE
//   pll_locked    in   PLL lock indicator, asynchronous to refclk
//   clear_fail    in   single-cycle pulse, leaves FAIL
//   pll_rst       out  active-high PLL reset
//   ready         out  lock qualified
//   fail          out  retries exhausted
//   state         out  current state encoding
//   retry_cnt     out  retries used in the current bring-up
//   lock_loss_cnt out  (LOCK_LOSS_COUNT_EN only) READY lock-loss count
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_FILTER_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16,
    parameter int RETRY_W             = 4
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               pll_locked,
    input  logic               clear_fail,
    output logic               pll_rst,
    output logic               ready,
    output logic               fail,
    output logic [2:0]         state,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [15:0]        lock_loss_cnt
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_FILTER = 3'd3;
    localparam logic [2:0] S_READY  = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   FLT_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic [1:0]         sync;
    logic               locked_s;
    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   timer_q;
    logic [RETRY_W-1:0] retry_q, retry_d;

    // Two-flop synchronizer for the asynchronous lock indicator
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], pll_locked};
    end
    assign locked_s = sync[1];

    // State register, shared timer and retry counter
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            // Timer restarts on every transition; only the timed states advance it
            if (state_d != state_q)
                timer_q <= '0;
            else if (state_q == S_RESET || state_q == S_WAIT || state_q == S_FILTER)
                timer_q <= timer_q + CNT_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RESET;
                    retry_d = '0;
                end
                S_RESET: begin
                    if (timer_q == RST_LAST) state_d = S_WAIT;
                end
                S_WAIT: begin
                    // Lock takes precedence over a coincident timeout
                    if (locked_s) begin
                        state_d = S_FILTER;
                    end else if (timer_q == TO_LAST) begin
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_RESET;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end
                end
                S_FILTER: begin
                    if (!locked_s)              state_d = S_WAIT;
                    else if (timer_q == FLT_LAST) state_d = S_READY;
                end
                S_READY: begin
                    if (!locked_s) begin
                        state_d = S_RESET;
                        retry_d = '0;
                    end
                end
                S_FAIL: begin
                    if (clear_fail) begin
                        state_d = S_IDLE;
                        retry_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        pll_rst = 1'b1;
        ready   = 1'b0;
        fail    = 1'b0;
        case (state_q)
            S_WAIT, S_FILTER: pll_rst = 1'b0;
            S_READY: begin
                pll_rst = 1'b0;
                ready   = 1'b1;
            end
            S_FAIL:  fail = 1'b1;
            default: pll_rst = 1'b1;
        endcase
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

`ifdef LOCK_LOSS_COUNT_EN
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            lock_loss_cnt <= 16'h0000;
        else if (state_q == S_READY && state_d == S_RESET && lock_loss_cnt != 16'hFFFF)
            lock_loss_cnt <= lock_loss_cnt + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int RH   = 4;
    localparam int FLT  = 8;
    localparam int TO   = 32;
    localparam int MAXR = 2;

    localparam int P_IDLE = 0, P_RST = 1, P_WAIT = 2, P_FILT = 3, P_RDY = 4, P_FAIL = 5;

    logic       refclk = 1'b0;
    logic       rst_n, enable, pll_locked, clear_fail;
    logic       pll_rst, ready, fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;
`ifdef LOCK_LOSS_COUNT_EN
    logic [15:0] lock_loss_cnt;
`endif

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES(RH), .LOCK_FILTER_CYCLES(FLT), .LOCK_TIMEOUT_CYCLES(TO),
        .MAX_RETRIES(MAXR), .CNT_W(16), .RETRY_W(4)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .enable(enable), .pll_locked(pll_locked),
        .clear_fail(clear_fail), .pll_rst(pll_rst), .ready(ready), .fail(fail),
        .state(state), .retry_cnt(retry_cnt)
`ifdef LOCK_LOSS_COUNT_EN
        , .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #10 refclk = ~refclk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: phase, cycles spent in phase, attempt count, lock history
    int m_ph, m_t, m_try, m_loss;
    bit lk_hist [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_t = 0; m_try = 0; m_loss = 0;
        lk_hist[0] = 0; lk_hist[1] = 0;
    endtask

    // One rising edge of the sequencer, computed from the behavioural rules
    task automatic model_edge();
        bit ls;
        int np, ntry;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls = lk_hist[1];
        lk_hist[1] = lk_hist[0];
        lk_hist[0] = pll_locked;
        np = m_ph; ntry = m_try;
        if (!enable) np = P_IDLE;
        else case (m_ph)
            P_IDLE: begin np = P_RST; ntry = 0; end
            P_RST:  if (m_t == RH - 1) np = P_WAIT;
            P_WAIT: begin
                if (ls) np = P_FILT;
                else if (m_t == TO - 1) begin
                    if (m_try == MAXR) np = P_FAIL;
                    else begin np = P_RST; ntry = m_try + 1; end
                end
            end
            P_FILT: if (!ls) np = P_WAIT; else if (m_t == FLT - 1) np = P_RDY;
            P_RDY:  if (!ls) begin
                        np = P_RST; ntry = 0;
                        if (m_loss < 65535) m_loss++;
                    end
            P_FAIL: if (clear_fail) begin np = P_IDLE; ntry = 0; end
            default: np = P_IDLE;
        endcase
        m_t   = (np == m_ph) ? m_t + 1 : 0;
        m_ph  = np;
        m_try = ntry;
    endtask

    task automatic compare();
        chk("state", 32'(state), 32'(m_ph));
        chk("pll_rst", 32'(pll_rst), 32'(m_ph == P_IDLE || m_ph == P_RST || m_ph == P_FAIL));
        chk("ready", 32'(ready), 32'(m_ph == P_RDY));
        chk("fail", 32'(fail), 32'(m_ph == P_FAIL));
        chk("retry_cnt", 32'(retry_cnt), 32'(m_try));
`ifdef LOCK_LOSS_COUNT_EN
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
    endtask

    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        compare();
    endtask

    // Step until the DUT reports the target state, bounded
    task automatic wait_state(input int target, input int limit, input string tag);
        for (int i = 0; i < limit && 32'(state) != target; i++) step();
        chk(tag, 32'(state), 32'(target));
    endtask

    initial begin
        int n_rst, n_flt;
        bit seen_wait;
        rst_n = 0; enable = 0; pll_locked = 0; clear_fail = 0;
        model_reset();

        // 1. reset values, then nominal bring-up with lock tied high
        repeat (3) step();
        chk("rst_state", 32'(state), 0);
        chk("rst_pll_rst", 32'(pll_rst), 1);
        rst_n = 1; pll_locked = 1;
        step();
        enable = 1;
        n_rst = 0;
        for (int i = 0; i < 40 && state != 3'd2; i++) begin
            step();
            if (state == 3'd1) n_rst++;
        end
        chk("rst_len", 32'(n_rst), RH);
        n_flt = 0;
        for (int i = 0; i < 40 && !ready; i++) begin
            step();
            if (state == 3'd3) n_flt++;
        end
        chk("flt_len", 32'(n_flt), FLT);
        chk("nom_ready", 32'(ready), 1);

        // 2. lock never arrives: three attempts then FAIL
        enable = 0; pll_locked = 0;
        step();
        enable = 1;
        wait_state(P_FAIL, 3 * (RH + TO) + 10, "exhaust_state");
        chk("exhaust_fail", 32'(fail), 1);
        chk("exhaust_retry", 32'(retry_cnt), MAXR);
        repeat (5) step();
        clear_fail = 1;
        step();
        clear_fail = 0;
        chk("clr_idle", 32'(state), P_IDLE);
        step();
        chk("clr_reset", 32'(state), P_RST);
        chk("clr_retry", 32'(retry_cnt), 0);

        // 3. single-cycle lock dropout while filtering
        pll_locked = 1;
        wait_state(P_FILT, 40, "glitch_filter");
        repeat (5) step();
        pll_locked = 0;
        step();
        pll_locked = 1;
        seen_wait = 0;
        for (int i = 0; i < 40 && !ready; i++) begin
            step();
            if (state == 3'd2) seen_wait = 1;
        end
        chk("glitch_rewait", 32'(seen_wait), 1);
        chk("glitch_ready", 32'(ready), 1);
        chk("glitch_retry", 32'(retry_cnt), 0);

        // 4. lock lost while READY
        pll_locked = 0;
        repeat (3) step();
        chk("loss_state", 32'(state), P_RST);
        chk("loss_ready", 32'(ready), 0);
`ifdef LOCK_LOSS_COUNT_EN
        chk("loss_cnt", 32'(lock_loss_cnt), 1);
`endif
        pll_locked = 1;
        wait_state(P_RDY, 60, "relock");

        // 5a. enable drop mid-FILTER
        enable = 0;
        step();
        enable = 1;
        wait_state(P_FILT, 40, "en_filter");
        repeat (3) step();
        enable = 0;
        step();
        chk("en_idle", 32'(state), P_IDLE);

        // 5b. lock arriving exactly at the timeout edge
        pll_locked = 0; enable = 1;
        for (int i = 0; i < 100 && !(m_ph == P_WAIT && m_t == TO - 3); i++) step();
        pll_locked = 1;
        repeat (3) step();
        chk("coinc_filter", 32'(state), P_FILT);
        chk("coinc_retry", 32'(retry_cnt), 0);

        // 5c. asynchronous reset in WAIT_LOCK
        pll_locked = 0;
        wait_state(P_WAIT, 20, "arst_wait");
        repeat (2) step();
        #3 rst_n = 0;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_pll_rst", 32'(pll_rst), 1);
        chk("arst_ready", 32'(ready), 0);
        chk("arst_fail", 32'(fail), 0);
        chk("arst_retry", 32'(retry_cnt), 0);
        model_reset();
        step();
        rst_n = 1;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            enable     = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
            clear_fail = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
